branch_control: RTL and testbench

//  Control-flow stage directly upstream of the program counter. Takes decoded

---
 rtl/branch_control_if.sv | 48 ++++
 rtl/branch_control.sv | 220 ++++++++++++++++++++++
 tb/tb_branch_control.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_control_if.sv
// Purpose: bundles the decoded-op, flag and counter-control signals of branch_control.
// Latency: n/a (wires only).
// Backpressure: none; the stage signals busy to its producer through Flush.
interface branch_control_if #(
  parameter int ADDR_W      = 16,
  parameter int OFF_W       = 9,
  parameter int STACK_DEPTH = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  // Decoded op side
  logic [ADDR_W-1:0]  PcValue;
  logic               InstrValid;
  logic [2:0]         Opcode;
  logic [1:0]         Cond;
  logic [ADDR_W-1:0]  Target;
  logic [OFF_W-1:0]   Offset;

  // ALU flag side
  logic               FlagsValid;
  logic               FlagZ;
  logic               FlagC;

  // Program counter control side
  logic               LoadEnable;
  logic [ADDR_W-1:0]  LoadValue;
  logic               OffsetEnable;
  logic [OFF_W-1:0]   OffsetOut;
  logic               Flush;
  logic [DEPTH_W-1:0] StackDepth;
  logic               StackError;

  // Producer of ops/flags, consumer of redirects
  modport master (
    output PcValue, InstrValid, Opcode, Cond, Target, Offset,
    output FlagsValid, FlagZ, FlagC,
    input  LoadEnable, LoadValue, OffsetEnable, OffsetOut,
    input  Flush, StackDepth, StackError
  );

  // The branch_control stage itself
  modport slave (
    input  PcValue, InstrValid, Opcode, Cond, Target, Offset,
    input  FlagsValid, FlagZ, FlagC,
    output LoadEnable, LoadValue, OffsetEnable, OffsetOut,
    output Flush, StackDepth, StackError
  );
endinterface

// File: rtl/branch_control.sv
// Purpose: resolves JMP/BR/CALL/RET into program-counter load/offset pulses, keeps a
//   return-address stack and flushes wrong-path ops. Optional macro BRANCH_TRAP_EN
//   makes stack overflow/underflow redirect to TRAP_VECTOR.
// Latency: op accepted at edge N -> pulse in cycle N+1 -> Flush through N+1+FLUSH_CYCLES.
// Backpressure: none on input; ops presented while Flush is high are ignored.
module branch_control #(
  parameter int          ADDR_W       = 16,
  parameter int          OFF_W        = 9,
  parameter int          STACK_DEPTH  = 8,
  parameter int          FLUSH_CYCLES = 2,
  parameter int unsigned TRAP_VECTOR  = 32'h0000_FFF0
) (
  input  logic          Clock,
  input  logic          Reset,
  branch_control_if.slave bus
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;
  localparam int CNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BR   = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;

`ifdef BRANCH_TRAP_EN
  localparam logic [ADDR_W-1:0] TRAP_ADDR = ADDR_W'(TRAP_VECTOR);
`endif

  // Elaboration-time parameter sanity checks
  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("branch_control: STACK_DEPTH must be a power of two >= 2");
  end
  if (FLUSH_CYCLES < 1) begin : g_bad_flush
    $error("branch_control: FLUSH_CYCLES must be >= 1");
  end
  if (ADDR_W < 32 && (TRAP_VECTOR >> ADDR_W) != 0) begin : g_bad_trap
    $error("branch_control: TRAP_VECTOR does not fit in ADDR_W bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load_en_q, load_en_d;
  logic                off_en_q, off_en_d;
  logic [ADDR_W-1:0]   load_val_q, load_val_d;
  logic [OFF_W-1:0]    off_val_q, off_val_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                err_q, err_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];

  logic                push_en;
  logic [ADDR_W-1:0]   ret_addr;
  logic [PTR_W-1:0]    top_idx;
  logic                stack_full;
  logic                stack_empty;
  logic                cond_ok;

  assign ret_addr    = bus.PcValue + ADDR_W'(1);
  assign top_idx     = PTR_W'(depth_q - DEPTH_W'(1));
  assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);

  // Condition code against the flags registered before this cycle
  always_comb begin
    cond_ok = 1'b0;
    case (bus.Cond)
      2'd0:    cond_ok = 1'b1;
      2'd1:    cond_ok = flag_z_q;
      2'd2:    cond_ok = ~flag_z_q;
      default: cond_ok = flag_c_q;
    endcase
  end

  // FSM next state, redirect decode, stack bookkeeping and flag capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_en_d  = 1'b0;
    off_en_d   = 1'b0;
    load_val_d = load_val_q;
    off_val_d  = off_val_q;
    depth_d    = depth_q;
    err_d      = err_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    push_en    = 1'b0;

    if (bus.FlagsValid) begin
      flag_z_d = bus.FlagZ;
      flag_c_d = bus.FlagC;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.InstrValid) begin
          case (bus.Opcode)
            OP_JMP: begin
              if (cond_ok) begin
                load_en_d  = 1'b1;
                load_val_d = bus.Target;
                state_d    = ST_REDIRECT;
              end
            end
            OP_BR: begin
              if (cond_ok) begin
                off_en_d  = 1'b1;
                off_val_d = bus.Offset;
                state_d   = ST_REDIRECT;
              end
            end
            OP_CALL: begin
              // CALL always redirects; a full stack only loses the return address
              load_en_d = 1'b1;
              state_d   = ST_REDIRECT;
              if (stack_full) begin
                err_d = 1'b1;
`ifdef BRANCH_TRAP_EN
                load_val_d = TRAP_ADDR;
`else
                load_val_d = bus.Target;
`endif
              end else begin
                push_en    = 1'b1;
                depth_d    = depth_q + DEPTH_W'(1);
                load_val_d = bus.Target;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                err_d = 1'b1;
`ifdef BRANCH_TRAP_EN
                load_en_d  = 1'b1;
                load_val_d = TRAP_ADDR;
                state_d    = ST_REDIRECT;
`endif
              end else begin
                load_en_d  = 1'b1;
                load_val_d = stack_q[top_idx];
                depth_d    = depth_q - DEPTH_W'(1);
                state_d    = ST_REDIRECT;
              end
            end
            default: ;
          endcase
        end
      end
      ST_REDIRECT: begin
        state_d = ST_FLUSH;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and control registers; reset aborts any redirect or flush in progress
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      load_en_q  <= 1'b0;
      off_en_q   <= 1'b0;
      load_val_q <= '0;
      off_val_q  <= '0;
      depth_q    <= '0;
      err_q      <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_en_q  <= load_en_d;
      off_en_q   <= off_en_d;
      load_val_q <= load_val_d;
      off_val_q  <= off_val_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
    end
  end

  // Return-address storage; contents above depth_q are don't-care so no reset
  always_ff @(posedge Clock) begin
    if (push_en) begin
      stack_q[depth_q[PTR_W-1:0]] <= ret_addr;
    end
  end

  // Address/offset are forced to zero outside their pulse so idle outputs stay quiet
  assign bus.LoadEnable   = load_en_q;
  assign bus.LoadValue    = load_en_q ? load_val_q : '0;
  assign bus.OffsetEnable = off_en_q;
  assign bus.OffsetOut    = off_en_q ? off_val_q : '0;
  assign bus.Flush        = (state_q != ST_IDLE);
  assign bus.StackDepth   = depth_q;
  assign bus.StackError   = err_q;

  // The two counter commands are mutually exclusive and only issued in REDIRECT
  a_one_pulse: assert property (@(posedge Clock) disable iff (Reset)
    !(load_en_q && off_en_q));
  a_pulse_in_redirect: assert property (@(posedge Clock) disable iff (Reset)
    (load_en_q || off_en_q) |-> (state_q == ST_REDIRECT));

endmodule

// File: tb/tb_branch_control.sv
// Purpose: randomized and directed stimulus for branch_control against a cycle-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_control;

  localparam int          ADDR_W       = 16;
  localparam int          OFF_W        = 9;
  localparam int          STACK_DEPTH  = 8;
  localparam int          FLUSH_CYCLES = 2;
  localparam int unsigned TRAP_VECTOR  = 32'h0000_FFF0;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  branch_control_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_DEPTH(STACK_DEPTH)) bus();

  branch_control #(
    .ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_DEPTH(STACK_DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES), .TRAP_VECTOR(TRAP_VECTOR)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs must show in the current cycle
  bit                m_flush;
  int                m_left;
  bit                m_le;
  bit                m_oe;
  logic [ADDR_W-1:0] m_lv;
  logic [OFF_W-1:0]  m_ov;
  logic [ADDR_W-1:0] m_stack[$];
  bit                m_err;
  bit                m_z;
  bit                m_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_flush = 1'b0;
    m_left  = 0;
    m_le    = 1'b0;
    m_oe    = 1'b0;
    m_lv    = '0;
    m_ov    = '0;
    m_stack.delete();
    m_err   = 1'b0;
    m_z     = 1'b0;
    m_c     = 1'b0;
  endtask

  // Applies the currently driven inputs to the model as of the next rising edge
  task automatic model_edge();
    bit accept, ok, new_le, new_oe;
    logic [ADDR_W-1:0] ra;
    new_le = 1'b0;
    new_oe = 1'b0;
    ok     = 1'b0;
    accept = bus.InstrValid && !m_flush;
    if (accept) begin
      case (bus.Cond)
        2'd0:    ok = 1'b1;
        2'd1:    ok = m_z;
        2'd2:    ok = !m_z;
        default: ok = m_c;
      endcase
      case (bus.Opcode)
        3'd1: if (ok) begin new_le = 1'b1; m_lv = bus.Target; end
        3'd2: if (ok) begin new_oe = 1'b1; m_ov = bus.Offset; end
        3'd3: begin
          new_le = 1'b1;
          if (m_stack.size() == STACK_DEPTH) begin
            m_err = 1'b1;
`ifdef BRANCH_TRAP_EN
            m_lv = ADDR_W'(TRAP_VECTOR);
`else
            m_lv = bus.Target;
`endif
          end else begin
            ra = bus.PcValue + 16'd1;
            m_stack.push_back(ra);
            m_lv = bus.Target;
          end
        end
        3'd4: begin
          if (m_stack.size() == 0) begin
            m_err = 1'b1;
`ifdef BRANCH_TRAP_EN
            new_le = 1'b1;
            m_lv   = ADDR_W'(TRAP_VECTOR);
`endif
          end else begin
            new_le = 1'b1;
            m_lv   = m_stack.pop_back();
          end
        end
        default: ;
      endcase
    end
    if (bus.FlagsValid) begin
      m_z = bus.FlagZ;
      m_c = bus.FlagC;
    end
    m_le = new_le;
    m_oe = new_oe;
    if (new_le || new_oe) begin
      m_flush = 1'b1;
      m_left  = FLUSH_CYCLES;
    end else if (m_left > 0) begin
      m_flush = 1'b1;
      m_left--;
    end else begin
      m_flush = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("LoadEnable", 32'(bus.LoadEnable), 32'(m_le));
    check("OffsetEnable", 32'(bus.OffsetEnable), 32'(m_oe));
    if (m_le) check("LoadValue", 32'(bus.LoadValue), 32'(m_lv));
    if (m_oe) check("OffsetOut", 32'(bus.OffsetOut), 32'(m_ov));
    check("Flush", 32'(bus.Flush), 32'(m_flush));
    check("StackDepth", 32'(bus.StackDepth), m_stack.size());
    check("StackError", 32'(bus.StackError), 32'(m_err));
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [1:0] cond,
                       input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt,
                       input logic [OFF_W-1:0] off, input bit fv, input bit fz, input bit fc);
    bus.InstrValid = v;
    bus.Opcode     = op;
    bus.Cond       = cond;
    bus.PcValue    = pc;
    bus.Target     = tgt;
    bus.Offset     = off;
    bus.FlagsValid = fv;
    bus.FlagZ      = fz;
    bus.FlagC      = fc;
    model_edge();
    @(posedge Clock);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 2'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.InstrValid = 1'b0;
    bus.FlagsValid = 1'b0;
    @(posedge Clock);
    #1;
    check("rst_LoadEnable", 32'(bus.LoadEnable), 0);
    check("rst_LoadValue", 32'(bus.LoadValue), 0);
    check("rst_OffsetEnable", 32'(bus.OffsetEnable), 0);
    check("rst_OffsetOut", 32'(bus.OffsetOut), 0);
    check("rst_Flush", 32'(bus.Flush), 0);
    check("rst_StackDepth", 32'(bus.StackDepth), 0);
    check("rst_StackError", 32'(bus.StackError), 0);
    Reset = 1'b0;
    model_clear();
  endtask

  initial begin
    bit v, fv;
    logic [2:0] op;
    int r;
    logic [ADDR_W-1:0] pc;

    bus.InstrValid = 1'b0; bus.Opcode = '0; bus.Cond = '0; bus.PcValue = '0;
    bus.Target = '0; bus.Offset = '0; bus.FlagsValid = 1'b0; bus.FlagZ = 1'b0; bus.FlagC = 1'b0;
    model_clear();
    #2;
    do_reset();
    idle(2);

    // Underflow on an empty stack, then an unconditional JMP
    drive(1, 3'd4, 2'd0, 16'h0010, 16'h0000, 9'h000, 0, 0, 0);
    idle(4);
    drive(1, 3'd1, 2'd0, 16'h0100, 16'h0123, 9'h000, 0, 0, 0);
    idle(4);

    // Reset asserted part-way through a flush
    drive(1, 3'd1, 2'd0, 16'h0100, 16'h0456, 9'h000, 0, 0, 0);
    idle(1);
    #2;
    Reset = 1'b1;
    #1;
    check("async_Flush", 32'(bus.Flush), 0);
    do_reset();

    // Flag-conditioned branches, including flags arriving with the branch
    drive(0, 3'd0, 2'd0, 16'h0000, 16'h0000, 9'h000, 1, 1, 0);
    drive(1, 3'd2, 2'd1, 16'h0200, 16'h0000, 9'h010, 0, 0, 0);
    idle(4);
    drive(1, 3'd2, 2'd2, 16'h0210, 16'h0000, 9'h020, 0, 0, 0);
    idle(2);
    drive(1, 3'd2, 2'd1, 16'h0220, 16'h0000, 9'h033, 1, 0, 1);
    idle(4);
    drive(1, 3'd2, 2'd1, 16'h0230, 16'h0000, 9'h044, 0, 0, 0);
    drive(1, 3'd1, 2'd3, 16'h0231, 16'h0777, 9'h000, 0, 0, 0);
    idle(4);

    // CALL then RET
    drive(1, 3'd3, 2'd2, 16'h0040, 16'h0200, 9'h000, 0, 0, 0);
    idle(4);
    drive(1, 3'd4, 2'd0, 16'h0200, 16'h0000, 9'h000, 0, 0, 0);
    idle(4);

    // Nine CALLs overflow the stack, then drain it past empty
    for (int i = 0; i < 9; i++) begin
      drive(1, 3'd3, 2'd0, 16'(i * 16), 16'(16'h1000 + i), 9'h000, 0, 0, 0);
      idle(3);
    end
    for (int i = 0; i < 9; i++) begin
      drive(1, 3'd4, 2'd0, 16'h2000, 16'h0000, 9'h000, 0, 0, 0);
      idle(3);
    end

    // Return address wraps at the top of the address space
    do_reset();
    drive(1, 3'd3, 2'd0, 16'hFFFF, 16'h1234, 9'h000, 0, 0, 0);
    idle(3);
    drive(1, 3'd4, 2'd0, 16'h1234, 16'h0000, 9'h000, 0, 0, 0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        r  = $urandom_range(0, 9);
        op = (r < 3) ? 3'd3 : (r < 6) ? 3'd4 : 3'($urandom_range(0, 7));
        v  = ($urandom_range(0, 3) != 0);
        fv = ($urandom_range(0, 2) == 0);
        pc = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
        drive(v, op, 2'($urandom), pc, 16'($urandom), 9'($urandom), fv,
              1'($urandom), 1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
